// File: rtl/replay_fifo_pkg.sv
// replay_fifo_pkg: shared defaults and pointer helpers
// for the replay FIFO family.
package replay_fifo_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_ADDR_W = 9;

   // Modular distance a - b; callers truncate to ADDR_W+1 bits.
   function automatic logic [31:0] ptr_dist(
      input logic [31:0] a,
      input logic [31:0] b
   );
      return a - b;
   endfunction

endpackage

// File: rtl/replay_fifo_ram.sv
// replay_fifo_ram: DEPTH x DATA_W simple dual-port RAM
// with one write port and a registered, clearable read port.
module replay_fifo_ram
   import replay_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // Storage write port; contents survive clr.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Registered read port; holds when not enabled.
   always_ff @(posedge clk) begin
      if (clr) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/replay_fifo_param.sv
// replay_fifo_param: width/depth-generic replay FIFO with mark/replay.
// Optional sticky overflow/underflow flags under REPLAY_FIFO_ERR_EN.
module replay_fifo_param
   import replay_fifo_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int AUTO_MARK = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] wdata,
   input  logic              write,
   input  logic              read,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   input  logic              replay,
   input  logic              mark,
   input  logic              erase,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count
`ifdef REPLAY_FIFO_ERR_EN
   ,
   output logic              overflow,
   output logic              underflow
`endif
);

   localparam int PW = ADDR_W + 1;
   localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};

   logic [PW-1:0] rd_q, rd_d;
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] mark_q, mark_d;
   logic          rvalid_q;
   logic [PW-1:0] held;
   logic          clr;
   logic          wr_acc;
   logic          rd_acc;

   assign clr    = reset | erase;
   assign held   = PW'(ptr_dist(32'(wr_q), 32'(mark_q)));
   assign count  = PW'(ptr_dist(32'(wr_q), 32'(rd_q)));
   assign empty  = (rd_q == wr_q);
   assign full   = (held == DEPTH_P);
   assign wr_acc = write & ~full;
   // Replay wins over read: the read is dropped that cycle.
   assign rd_acc = read & ~empty & ~replay;
   assign rvalid = rvalid_q;

   // Next-state pointers; mark follows the post-read rd pointer.
   always_comb begin
      rd_d   = rd_q;
      wr_d   = wr_q;
      mark_d = mark_q;
      if (replay) begin
         rd_d = mark_q;
      end else if (rd_acc) begin
         rd_d = rd_q + PW'(1);
      end
      if (wr_acc) begin
         wr_d = wr_q + PW'(1);
      end
      if (!replay) begin
         if (mark) begin
            mark_d = rd_d;
         end else if ((AUTO_MARK != 0) && wr_acc && empty) begin
            mark_d = wr_q;
         end
      end
   end

   // Pointer and read-valid registers; erase acts like reset.
   always_ff @(posedge clk) begin
      if (clr) begin
         rd_q     <= '0;
         wr_q     <= '0;
         mark_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         mark_q   <= mark_d;
         rvalid_q <= rd_acc;
      end
   end

`ifdef REPLAY_FIFO_ERR_EN
   logic ovf_q;
   logic unf_q;

   // Sticky error flags for dropped write/read requests.
   always_ff @(posedge clk) begin
      if (clr) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (write && full) begin
            ovf_q <= 1'b1;
         end
         if (read && empty && !replay) begin
            unf_q <= 1'b1;
         end
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;
`endif

   replay_fifo_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .clr   (clr),
      .we    (wr_acc & ~clr),
      .waddr (wr_q[ADDR_W-1:0]),
      .wdata (wdata),
      .re    (rd_acc & ~clr),
      .raddr (rd_q[ADDR_W-1:0]),
      .rdata (rdata)
   );

endmodule

// File: doc/replay_fifo_param.md
Name: replay_fifo_param

Overview:
Parametrised, width/depth-generic replay FIFO; next generation of the team's 8-bit x 512 replay buffer used between the UART/keypad byte producers and display/transmit consumers.
- Adds: full flag with write protection of replayable data, explicit mark command, occupancy count, read-valid strobe, and a selectable auto-mark mode.
- Replay rewinds the read pointer to a mark pointer. Data between mark and write pointer is never overwritten until the mark advances.

Parameters:
- DATA_W, 8, data width in bits.
- ADDR_W, 9, address width; DEPTH = 2**ADDR_W entries.
- AUTO_MARK, 1, if 1, an accepted write into an empty FIFO (rd_ptr==wr_ptr) also sets mark_ptr <= wr_ptr; if 0, the mark moves only on mark/erase/reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- wdata  in  DATA_W  write data.
- write  in  1  write request; accepted iff write & ~full.
- read  in  1  read request; accepted iff read & ~empty.
- rdata  out  DATA_W  registered read data, valid when rvalid=1.
- rvalid  out  1  high the cycle after an accepted read.
- replay  in  1  rd_ptr <= mark_ptr.
- mark  in  1  mark_ptr <= rd_ptr (releases already-read data).
- erase  in  1  clear all pointers (same effect as reset on pointers).
- empty  out  1  rd_ptr == wr_ptr.
- full  out  1  (wr_ptr - mark_ptr) == DEPTH.
- count  out  ADDR_W+1  wr_ptr - rd_ptr (unread entries).

Behaviour:
- Pointers rd_ptr, wr_ptr, mark_ptr are ADDR_W+1 bits, wrap modulo 2**(ADDR_W+1); RAM index = ptr[ADDR_W-1:0].
- Invariant: mark_ptr <= rd_ptr <= wr_ptr (modular distance); wr_ptr - mark_ptr <= DEPTH.
- Reset or erase (sync): rd_ptr = wr_ptr = mark_ptr = 0; rdata = 0; rvalid = 0; empty = 1, full = 0, count = 0. RAM contents are not cleared.
- Priority each cycle: reset > erase > (pointer updates below). Erase cancels any same-cycle write, read, mark or replay.
- Write accepted: mem[wr_ptr] <= wdata; wr_ptr +1. Write while full is dropped; no pointer or RAM change.
- Read accepted: rdata <= mem[rd_ptr] (1-cycle latency), rvalid <= 1, rd_ptr +1. Read while empty: rvalid <= 0, rdata holds.
- rdata holds its last value whenever rvalid = 0.
- Replay: rd_ptr <= mark_ptr. Replay beats read and mark in the same cycle: read is ignored and rvalid <= 0.
- Write in the same cycle as replay is accepted normally.
- Mark (no replay): mark_ptr <= rd_ptr value after this cycle's read increment. Mark and read together therefore release the byte just read.
- AUTO_MARK=1: accepted write while empty sets mark_ptr <= wr_ptr (pre-increment). Explicit mark in the same cycle takes precedence; both give the same value when empty.
- Flags and count are combinational from registered pointers, so they reflect state after the last clock edge.
- Simultaneous accepted read and write when count==1: empty stays 0 after the edge; count unchanged.
- Full is based on mark_ptr, not rd_ptr: an unmarked FIFO fills after DEPTH writes even if all have been read.

Optional Feature:
- Macro REPLAY_FIFO_ERR_EN.
- Defined: adds outputs overflow and underflow (1 bit each), sticky. Set by write&full and by read&empty (replay not asserted) respectively. Cleared only by reset or erase.
- Undefined: these ports and registers are absent; dropped requests are silent.

Decomposition:
- Shared header/package replay_fifo_pkg: default DATA_W/ADDR_W constants, and a pointer-distance function (wr - mark, wr - rd) in ADDR_W+1 bits.
- One sub-module, replay_fifo_ram: simple dual-port synchronous RAM, DEPTH x DATA_W, one write port and one registered read port with read-enable.
- The pointer/flag control stays in replay_fifo_param.

Test Plan:
Run with ADDR_W=2, DATA_W=8.
- Write 0x41,0x42,0x43 -> count=3, empty=0. Read x3 -> rdata 0x41,0x42,0x43 each with rvalid the following cycle; then empty=1.
- After the above (AUTO_MARK=1), replay -> next reads return 0x41,0x42,0x43 again; count back to 3 after replay.
- Write 4 bytes without mark -> full=1. Read all, write 0x55 -> dropped (full stays 1). Assert mark -> full=0, write 0x55 accepted, and replay then reads 0x55 only.
- Replay+read same cycle -> rvalid=0 next cycle, rd_ptr=mark_ptr. Erase with write same cycle -> empty=1, count=0, write lost.
- Pointer wrap: 10 write/read/mark cycles of 0x00..0x09 -> data in order, count never exceeds 1, full never asserted.
- With REPLAY_FIFO_ERR_EN: read on empty -> underflow=1 and stays 1. Write when full -> overflow=1. Erase -> both 0.
